rf_write_arbiter: RTL and testbench

Shares the register file's single write port between two sources:
- the pipeline writeback stage (WB), which has no handshake;
- the multi-cycle multiply/divide unit (MDU), which uses a valid/ready handshake.

---
 rtl/rf_write_arbiter_if.sv | 42 ++++
 rtl/rf_write_arbiter.sv | 114 +++++++++++
 tb/tb_rf_write_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/rf_write_arbiter_if.sv
// Register-file write-port bundle: WB request, MDU handshake, RF write, stall and hazard lookup.
// Optional statistics outputs appear when RFARB_STATS_EN is defined.
interface rf_write_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          wb_we;
  logic [AW-1:0] wb_rw;
  logic [DW-1:0] wb_wd;
  logic          mdu_valid;
  logic          mdu_ready;
  logic [AW-1:0] mdu_rw;
  logic [DW-1:0] mdu_wd;
  logic          rf_regWrite;
  logic [AW-1:0] rf_rw;
  logic [DW-1:0] rf_wd;
  logic          stall_req;
  logic [AW-1:0] q1;
  logic [AW-1:0] q2;
  logic          pend1;
  logic          pend2;
`ifdef RFARB_STATS_EN
  logic [15:0]   stat_mdu_writes;
  logic [15:0]   stat_stall_cycles;
`endif

  modport master (
    output wb_we, wb_rw, wb_wd, mdu_valid, mdu_rw, mdu_wd, q1, q2,
    input  mdu_ready, rf_regWrite, rf_rw, rf_wd, stall_req, pend1, pend2
`ifdef RFARB_STATS_EN
    , input stat_mdu_writes, stat_stall_cycles
`endif
  );

  modport slave (
    input  wb_we, wb_rw, wb_wd, mdu_valid, mdu_rw, mdu_wd, q1, q2,
    output mdu_ready, rf_regWrite, rf_rw, rf_wd, stall_req, pend1, pend2
`ifdef RFARB_STATS_EN
    , output stat_mdu_writes, stat_stall_cycles
`endif
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Shares the RF write port between WB (no handshake) and a queued MDU (valid/ready) with a starvation stall.
// Define RFARB_STATS_EN to add saturating MDU-write and stall-cycle counters.
module rf_write_arbiter #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int QDEPTH   = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  rf_write_arbiter_if.slave bus
);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int GW = $clog2(MAX_WAIT + 1);

  logic [AW-1:0] rw_q [QDEPTH];
  logic [DW-1:0] wd_q [QDEPTH];
  logic [PW-1:0] head, tail, off;
  logic [CW-1:0] count;
  logic [GW-1:0] age;
  logic          empty, full, stall, pop, enq, hit1, hit2;

  function automatic logic [GW-1:0] age_inc(input logic [GW-1:0] a);
    return (a >= GW'(MAX_WAIT)) ? GW'(MAX_WAIT) : a + GW'(1);
  endfunction

  assign empty         = (count == '0);
  assign full          = (count == CW'(QDEPTH));
  assign stall         = !rst && !empty && (age >= GW'(MAX_WAIT));
  assign bus.stall_req = stall;
  // Ready depends only on registered occupancy, so a pop this cycle cannot raise it.
  assign bus.mdu_ready = !rst && !full;
  assign enq           = bus.mdu_valid && bus.mdu_ready && (bus.mdu_rw != '0);

  always_comb begin
    pop             = 1'b0;
    bus.rf_regWrite = 1'b0;
    bus.rf_rw       = '0;
    bus.rf_wd       = '0;
    if (!rst) begin
      if (stall || (!bus.wb_we && !empty)) begin
        pop             = 1'b1;
        bus.rf_regWrite = 1'b1;
        bus.rf_rw       = rw_q[head];
        bus.rf_wd       = wd_q[head];
      end else if (bus.wb_we) begin
        bus.rf_regWrite = (bus.wb_rw != '0);
        bus.rf_rw       = bus.wb_rw;
        bus.rf_wd       = bus.wb_wd;
      end
    end
  end

  // An entry is live when its distance from head is below the occupancy.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    off  = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      off = PW'(i) - head;
      if ({1'b0, off} < count) begin
        if (rw_q[i] == bus.q1) hit1 = 1'b1;
        if (rw_q[i] == bus.q2) hit2 = 1'b1;
      end
    end
  end

  assign bus.pend1 = !rst && hit1 && (bus.q1 != '0);
  assign bus.pend2 = !rst && hit2 && (bus.q2 != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      age   <= '0;
    end else begin
      if (pop) head <= head + PW'(1);
      if (enq) tail <= tail + PW'(1);
      count <= count + CW'(enq) - CW'(pop);
      if (pop || empty) age <= '0;
      else              age <= age_inc(age);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      rw_q[tail] <= bus.mdu_rw;
      wd_q[tail] <= bus.mdu_wd;
    end
  end

`ifdef RFARB_STATS_EN
  logic [15:0] n_wr, n_stall;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      n_wr    <= '0;
      n_stall <= '0;
    end else begin
      if (pop)   n_wr    <= sat_inc16(n_wr);
      if (stall) n_stall <= sat_inc16(n_stall);
    end
  end

  assign bus.stat_mdu_writes   = n_wr;
  assign bus.stat_stall_cycles = n_stall;
`endif
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed plus randomized bench for rf_write_arbiter against a queue-based reference model.
module tb_rf_write_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int QDEPTH = 2;
  localparam int MAX_WAIT = 4;

  typedef struct packed {
    logic [AW-1:0] rw;
    logic [DW-1:0] wd;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  ent_t mq[$];
  int   wait_cnt = 0;
  int   e_nwr = 0;
  int   e_nstall = 0;

  rf_write_arbiter_if #(.DW(DW), .AW(AW)) bus ();

  rf_write_arbiter #(.DW(DW), .AW(AW), .QDEPTH(QDEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input int wrw, input logic [DW-1:0] wwd,
                       input logic mv, input int mrw, input logic [DW-1:0] mwd,
                       input int a1, input int a2);
    bus.wb_we     = we;
    bus.wb_rw     = AW'(wrw);
    bus.wb_wd     = wwd;
    bus.mdu_valid = mv;
    bus.mdu_rw    = AW'(mrw);
    bus.mdu_wd    = mwd;
    bus.q1        = AW'(a1);
    bus.q2        = AW'(a2);
  endtask

  // One clock: compare outputs mid-cycle against the model, then advance the model at the edge.
  task automatic cycle();
    int            n;
    logic          e_ready, e_stall, e_we, e_p1, e_p2, popped;
    logic [AW-1:0] e_rw;
    logic [DW-1:0] e_wd;
    ent_t          e;
    n = mq.size();
    @(negedge clk);
    e_ready = !rst && (n < QDEPTH);
    e_stall = !rst && (n > 0) && (wait_cnt >= MAX_WAIT);
    popped = 1'b0; e_we = 1'b0; e_rw = '0; e_wd = '0;
    if (!rst) begin
      if (e_stall || (!bus.wb_we && n > 0)) begin
        popped = 1'b1; e_we = 1'b1; e_rw = mq[0].rw; e_wd = mq[0].wd;
      end else if (bus.wb_we) begin
        e_we = (bus.wb_rw != '0); e_rw = bus.wb_rw; e_wd = bus.wb_wd;
      end
    end
    e_p1 = 1'b0; e_p2 = 1'b0;
    if (!rst) foreach (mq[k]) begin
      if (bus.q1 != '0 && mq[k].rw == bus.q1) e_p1 = 1'b1;
      if (bus.q2 != '0 && mq[k].rw == bus.q2) e_p2 = 1'b1;
    end
    chk("mdu_ready", 64'(bus.mdu_ready), 64'(e_ready));
    chk("stall_req", 64'(bus.stall_req), 64'(e_stall));
    chk("rf_regWrite", 64'(bus.rf_regWrite), 64'(e_we));
    chk("rf_rw", 64'(bus.rf_rw), 64'(e_rw));
    chk("rf_wd", 64'(bus.rf_wd), 64'(e_wd));
    chk("pend1", 64'(bus.pend1), 64'(e_p1));
    chk("pend2", 64'(bus.pend2), 64'(e_p2));
`ifdef RFARB_STATS_EN
    chk("stat_mdu_writes", 64'(bus.stat_mdu_writes), 64'(e_nwr));
    chk("stat_stall_cycles", 64'(bus.stat_stall_cycles), 64'(e_nstall));
`endif
    @(posedge clk);
    if (rst) begin
      mq.delete();
      wait_cnt = 0; e_nwr = 0; e_nstall = 0;
    end else begin
      if (popped || n == 0) wait_cnt = 0;
      else if (wait_cnt < MAX_WAIT) wait_cnt++;
      if (popped && e_nwr < 16'hFFFF) e_nwr++;
      if (e_stall && e_nstall < 16'hFFFF) e_nstall++;
      if (popped) void'(mq.pop_front());
      if (bus.mdu_valid && e_ready && bus.mdu_rw != '0) begin
        e.rw = bus.mdu_rw; e.wd = bus.mdu_wd;
        mq.push_back(e);
      end
    end
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;
    cycle();

    // Single MDU push with WB idle, then its write and pend window.
    drive(0, 0, 0, 1, 5, 32'hDEADBEEF, 5, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 5, 0);
    repeat (3) cycle();

    // Fill the queue under continuous WB writes and ride through both starvation stalls.
    drive(1, 9, 32'h1111_0009, 1, 3, 32'h3333_3333, 3, 4);
    cycle();
    drive(1, 9, 32'h1111_0009, 1, 4, 32'h4444_4444, 3, 4);
    cycle();
    drive(1, 10, 32'h2222_000A, 0, 0, 0, 3, 4);
    repeat (12) cycle();
    chk("queue_drained", 64'(mq.size()), 64'd0);

    // rw==0 MDU result is accepted but never queued.
    drive(0, 0, 0, 1, 0, 32'hCAFE_0000, 0, 0);
    repeat (2) cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    chk("rw0_not_queued", 64'(mq.size()), 64'd0);

    // WB to r0 is suppressed; WB beats a non-empty queue; head drains when WB idles.
    drive(1, 0, 32'h0BAD_0000, 1, 8, 32'h8888_8888, 8, 7);
    cycle();
    drive(1, 7, 32'h1, 0, 0, 0, 8, 7);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 8, 7);
    repeat (2) cycle();

    // Reset with two entries queued.
    drive(1, 12, 32'hABCD, 1, 6, 32'h6666, 6, 11);
    cycle();
    drive(1, 12, 32'hABCD, 1, 11, 32'hBBBB, 6, 11);
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 6, 11);
    repeat (2) cycle();

    // Randomized traffic: heavy WB load first to provoke stalls, lighter afterwards.
    for (int i = 0; i < 600; i++) begin
      int pct;
      pct = (i < 300) ? 85 : 40;
      rst = ($urandom_range(0, 79) == 0);
      drive($urandom_range(0, 99) < pct, $urandom_range(0, 7), $urandom,
            $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom,
            $urandom_range(0, 7), $urandom_range(0, 7));
      cycle();
    end
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
